// File: rtl/if_prefetch_queue_pkg.sv
// if_prefetch_queue_pkg: shared widths and the {pc, instr} queue entry type.
package if_prefetch_queue_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INCR = 1;
  localparam int ENTRY_W = 2 * XLEN;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_prefetch_queue_fetch_fifo.sv
// fetch_fifo: DEPTH-entry queue of fetch entries with synchronous flush; head read combinationally.
module fetch_fifo
  import if_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  fetch_entry_t               wr_data,
  input  logic                       rd_en,
  output fetch_entry_t               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign rd_data = fetch_entry_t'(mem[rd_ptr]);
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: issues in-order word fetches, buffers {pc, instr} responses, flushes on redirect.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            deq_valid,
  output logic [XLEN-1:0] deq_pc,
  output logic [XLEN-1:0] deq_pc_plus1,
  output logic [XLEN-1:0] deq_instr,
  input  logic            deq_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] count, outstanding, drop_cnt;
  logic [CW:0] live;
  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic req_fire, rsp_fire, enq, deq;
  fetch_entry_t head;
  // Stale in-flight requests will be dropped, so only live ones reserve a slot.
  assign live = {1'b0, outstanding} - {1'b0, drop_cnt} + {1'b0, count};
  assign imem_req_valid = rst & !redirect & !halt & (live < (CW+1)'(DEPTH)) & (outstanding < CW'(MAX_OUT));
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_fire = imem_rsp_valid & (outstanding != '0);
  assign enq = rsp_fire & (drop_cnt == '0) & !redirect;
  assign deq_valid = rst & (count != '0);
  assign deq = deq_valid & deq_ready & !redirect;
  assign deq_pc = head.pc;
  assign deq_pc_plus1 = head.pc + PC_INCR;
  assign deq_instr = head.instr;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .wr_en   (enq),
    .wr_data ('{pc: rsp_pc, instr: imem_rsp_data}),
    .rd_en   (deq),
    .rd_data (head),
    .count   (count)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      if (redirect) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop_cnt <= outstanding - CW'(rsp_fire);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_INCR;
        if (enq) rsp_pc <= rsp_pc + PC_INCR;
        if (rsp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      assert (count <= CW'(DEPTH));
      assert (outstanding <= CW'(MAX_OUT));
      assert (drop_cnt <= outstanding);
      assert (!(imem_rsp_valid && outstanding == '0));
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: random traffic against an in-order memory model and a queue-level reference.
module tb_if_prefetch_queue;
  logic clk = 0, rst = 0, redirect = 0, halt = 0;
  logic imem_req_ready = 0, imem_rsp_valid = 0, deq_ready = 0;
  logic [31:0] redirect_pc = 0, imem_rsp_data = 0;
  logic imem_req_valid, deq_valid;
  logic [31:0] imem_req_addr, deq_pc, deq_pc_plus1, deq_instr;
  typedef struct {
    logic [31:0] pc;
    int          due;
    bit          stale;
  } req_t;
  req_t pend[$];
  logic [31:0] mq[$];
  logic [31:0] fpc;
  int cyc, last_due, lat, n_chk, n_fail;
  int p_redirect, p_halt, p_ready, p_deq;
  if_prefetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .deq_valid      (deq_valid),
    .deq_pc         (deq_pc),
    .deq_pc_plus1   (deq_pc_plus1),
    .deq_instr      (deq_instr),
    .deq_ready      (deq_ready)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  task automatic step();
    logic rv, rsp;
    int live, due;
    req_t r;
    @(posedge clk);
    #1;
    rst = 1;
    redirect = $urandom_range(99) < p_redirect;
    case ($urandom_range(2))
      0: redirect_pc = 32'h40;
      1: redirect_pc = 32'hFFFF_FFFE;
      default: redirect_pc = $urandom;
    endcase
    halt = $urandom_range(99) < p_halt;
    imem_req_ready = $urandom_range(99) < p_ready;
    deq_ready = $urandom_range(99) < p_deq;
    rsp = pend.size() > 0 && pend[0].due <= cyc;
    imem_rsp_valid = rsp;
    imem_rsp_data = rsp ? word(pend[0].pc) : $urandom;
    @(negedge clk);
    live = mq.size();
    foreach (pend[i]) if (!pend[i].stale) live++;
    rv = !redirect && !halt && live < 4 && pend.size() < 2;
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, rv});
    if (rv) check("req_addr", imem_req_addr, fpc);
    check("deq_valid", {31'b0, deq_valid}, {31'b0, mq.size() > 0});
    if (mq.size() > 0) begin
      check("deq_pc", deq_pc, mq[0]);
      check("deq_pc_plus1", deq_pc_plus1, mq[0] + 32'd1);
      check("deq_instr", deq_instr, word(mq[0]));
    end
    if (!redirect && deq_ready && mq.size() > 0) void'(mq.pop_front());
    if (rsp) begin
      r = pend.pop_front();
      if (!r.stale && !redirect) mq.push_back(r.pc);
    end
    if (redirect) begin
      mq.delete();
      foreach (pend[i]) pend[i].stale = 1;
      fpc = redirect_pc;
    end else if (rv && imem_req_ready) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      pend.push_back('{pc: fpc, due: due, stale: 1'b0});
      last_due = due;
      fpc++;
    end
    cyc++;
  endtask
  task automatic phase(int l, int pr, int ph, int prdy, int pd, int n);
    lat = l; p_redirect = pr; p_halt = ph; p_ready = prdy; p_deq = pd;
    repeat (n) step();
  endtask
  initial begin
    fpc = 0; cyc = 0; last_due = -1; n_chk = 0; n_fail = 0;
    repeat (3) begin
      @(negedge clk);
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("rst_deq_valid", {31'b0, deq_valid}, 32'd0);
    end
    phase(1, 0, 0, 100, 100, 30);
    phase(1, 0, 0, 100, 0, 20);
    phase(1, 0, 0, 100, 100, 10);
    phase(3, 0, 0, 70, 80, 60);
    phase(2, 15, 0, 80, 70, 150);
    phase(3, 10, 30, 75, 60, 200);
    phase(1, 10, 30, 90, 50, 200);
    phase(2, 0, 0, 100, 100, 20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
